vector_sweep_driver: RTL
========================

# vector_sweep_driver

Sequential stimulus/response engine for the 4-input / 6-output combinational benchmark netlists in the dataset. It is the driving and observing end of a netlist's primary inputs and outputs: it sweeps all 2^N_IN input vectors, waits a settle interval, samples the outputs, and streams each (vector, response) record out over valid/ready. It also compacts all responses into a MISR signature, so balanced and unbalanced variants of one benchmark can be checked for equivalence on-chip or in simulation.

## Interface
- N_IN, 4, width of the netlist input vector (x0 = bit 0)
- N_OUT, 6, width of the netlist response (f1 = bit 0)
- SETTLE, 1, cycles between a vec_o change and the resp_i sample; legal range 1..15
- SIG_W, 16, MISR width; must be at least N_OUT
- POLY, 16'h1021, MISR feedback mask (Galois form)

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begins a sweep when sampled high in IDLE or DONE
- busy  out  1  high from the cycle after start is accepted until the sweep ends
- done  out  1  high in DONE; cleared by the next accepted start or by rst
- vec_o  out  N_IN  vector driven to the netlist inputs
- resp_i  in  N_OUT  netlist outputs, treated as combinational from vec_o
- rec_valid  out  1  record available
- rec_ready  in  1  consumer accepts the record
- rec_data  out  N_IN+N_OUT  {vector, response}; vector in the MSBs
- signature  out  SIG_W  MISR state, valid whenever done is high

## Operation
- FSM states: IDLE, DRIVE, EMIT, DONE.
- IDLE/DONE, start=1:
  - vec_o <= 0, signature <= 0, settle counter <= SETTLE-1, done <= 0, busy <= 1
  - next state is DRIVE
- DRIVE:
  - The settle counter decrements each cycle.
  - When the counter is 0, the block latches resp_i into the record register and updates the MISR.
  - Next state is EMIT.
- MISR update: sig <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero_extend(resp_i).
- EMIT:
  - rec_valid=1. rec_data and vec_o stay stable until rec_valid && rec_ready.
  - On acceptance when vec_o is the all-ones vector: go to DONE, busy <= 0, done <= 1.
  - On acceptance otherwise: vec_o <= vec_o+1, reload the settle counter, go to DRIVE.
- Wrap-around: vec_o never wraps within a sweep. The last vector is 2^N_IN-1. A new sweep restarts at 0.
- start while busy is ignored. start held high in DONE begins a new sweep at once.
- rec_ready low stalls EMIT indefinitely. The MISR is updated exactly once per vector, regardless of stall length.
- rst at any time:
  - state <= IDLE, vec_o <= 0, signature <= 0
  - busy, done and rec_valid go to 0
  - rec_data <= 0
  - Any partial sweep is discarded, and no record is emitted on the reset cycle.
- Reset values of all outputs are 0.

## Timing
- Start accepted in cycle T:
  - DRIVE begins at T+1 with vec_o=0.
  - Sample at cycle T+SETTLE.
  - rec_valid is first high at T+SETTLE+1.
- With rec_ready tied high, each vector takes SETTLE+1 cycles.
- For N_IN=4 and SETTLE=1, done rises at T+33 (16 vectors × 2 cycles, +1).
- rec_valid, rec_data, vec_o, busy, done and signature are all registered outputs. There is no combinational path from resp_i or rec_ready to any output.
- Handshake: transfer happens on a cycle with rec_valid && rec_ready. rec_valid never drops without a transfer, except on rst.

## Structure
- Shared package vsd_pkg holds:
  - the state enum (IDLE, DRIVE, EMIT, DONE)
  - the default POLY constant
  - the settle-counter width (4 bits)
- One sub-module, vsd_misr:
  - parameters SIG_W and POLY
  - ports clk, rst, clr, en, din[SIG_W], sig
  - the top level zero-extends resp_i into din.
- Top-level size target: about 200 lines including the MISR.

## Test plan
- **Loopback, zero response:** resp_i=0, rec_ready=1, SETTLE=1, pulse start.
  - Required: 16 records with rec_data = {i,6'b0} for i=0..15.
  - done at T+33; signature = 16'h0000.
- **Identity model:** resp_i = {2'b0, vec_o}.
  - Required: each record's response field equals its vector.
  - signature matches the bench's Galois MISR model using POLY=16'h1021.
- **Backpressure:** hold rec_ready low for 5 cycles on vectors 3 and 15.
  - Required: rec_data and vec_o stay stable during each stall.
  - Exactly 16 transfers; signature is identical to the unstalled run.
- **Settle:** SETTLE=3, with a model that delays resp_i by 2 cycles.
  - Required: every record is correct.
  - Per-vector period is 4 cycles; done at T+65.
- **Reset mid-sweep:** assert rst in EMIT of vector 7.
  - Required: next cycle shows all outputs 0 and state IDLE.
  - A new start produces a full 16-record sweep from vector 0.
- **Start abuse:**
  - start pulsed while busy is ignored; the record count stays 16.
  - start held high through DONE relaunches immediately. done is high for exactly 1 cycle, then busy=1.

Source files
------------

// File: rtl/vsd_pkg.sv
// Shared types and constants for the vector sweep driver and its MISR.
package vsd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_EMIT  = 2'd2,
    ST_DONE  = 2'd3
  } vsd_state_e;

  localparam logic [15:0] DEF_POLY = 16'h1021;
  localparam int unsigned CNT_W    = 4;

endpackage

// File: rtl/vsd_misr.sv
// Galois-form multiple-input signature register; clr wins over en.
module vsd_misr
  import vsd_pkg::*;
#(
  parameter int unsigned      SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [SIG_W-1:0] din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) sig_q <= '0;
    else     sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/vector_sweep_driver.sv
// Sweeps every input vector of a small combinational netlist, samples the
// settled response, streams {vector, response} records and compacts them.
module vector_sweep_driver
  import vsd_pkg::*;
#(
  parameter int unsigned      N_IN   = 4,
  parameter int unsigned      N_OUT  = 6,
  parameter int unsigned      SETTLE = 1,
  parameter int unsigned      SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEF_POLY)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [N_IN-1:0]       vec_o,
  input  logic [N_OUT-1:0]      resp_i,
  output logic                  rec_valid,
  input  logic                  rec_ready,
  output logic [N_IN+N_OUT-1:0] rec_data,
  output logic [SIG_W-1:0]      signature
);

  localparam int unsigned  REC_W       = N_IN + N_OUT;
  localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]  VEC_LAST    = '1;

  vsd_state_e        state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REC_W-1:0]  rec_q, rec_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              misr_clr_c;
  logic              misr_en_c;

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    rec_d      = rec_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    done_d     = done_q;
    misr_clr_c = 1'b0;
    misr_en_c  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_DRIVE;
          vec_d      = '0;
          cnt_d      = SETTLE_INIT;
          done_d     = 1'b0;
          busy_d     = 1'b1;
          misr_clr_c = 1'b1;
        end
      end
      ST_DRIVE: begin
        // Sample once per vector, so a stalled EMIT never re-clocks the MISR.
        if (cnt_q == '0) begin
          rec_d     = {vec_q, resp_i};
          misr_en_c = 1'b1;
          valid_d   = 1'b1;
          state_d   = ST_EMIT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_EMIT: begin
        if (valid_q && rec_ready) begin
          valid_d = 1'b0;
          if (vec_q == VEC_LAST) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            vec_d   = vec_q + N_IN'(1);
            cnt_d   = SETTLE_INIT;
            state_d = ST_DRIVE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      rec_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      rec_q   <= rec_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  vsd_misr #(
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (misr_clr_c),
    .en  (misr_en_c),
    .din (SIG_W'(resp_i)),
    .sig (signature)
  );

  assign vec_o     = vec_q;
  assign rec_data  = rec_q;
  assign rec_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
